// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// One requester holds the port for a burst of up to MAX_BURST words; writes are never issued while full.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            accept,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    cur_id,
    output logic                          busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t               state, state_n;
    logic [NUM_REQ-1:0]   gnt_n;
    logic [IW-1:0]        cur_id_n, last_id, last_id_n, sel, cand;
    logic [BW-1:0]        beat, beat_n;
    logic                 xfer;
    logic [FIFO_WIDTH-1:0] words [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    assign xfer         = req[cur_id] & gnt[cur_id] & ~fifo_full;
    assign fifo_wr_en   = xfer;
    assign accept       = gnt & {NUM_REQ{xfer}};
    assign fifo_data_in = words[cur_id];
    assign busy         = state == BURST;

    // Descending scan so the requester closest after last_id wins.
    always_comb begin
        sel  = last_id;
        cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IW'((int'(last_id) + k) % NUM_REQ);
            if (req[cand]) sel = cand;
        end
    end

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        cur_id_n  = cur_id;
        last_id_n = last_id;
        beat_n    = beat;
        if (state == IDLE) begin
            if (|req) begin
                state_n   = BURST;
                gnt_n     = NUM_REQ'(1) << sel;
                cur_id_n  = sel;
                last_id_n = sel;
                beat_n    = '0;
            end
        end else if (!req[cur_id] || (xfer && (req_last[cur_id] || beat == BW'(MAX_BURST - 1)))) begin
            state_n = IDLE;
            gnt_n   = '0;
        end else if (xfer) begin
            beat_n = beat + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= '0;
            cur_id  <= '0;
            last_id <= IW'(NUM_REQ - 1);
            beat    <= '0;
        end else begin
            state   <= state_n;
            gnt     <= gnt_n;
            cur_id  <= cur_id_n;
            last_id <= last_id_n;
            beat    <= beat_n;
        end
    end
endmodule
